// File: rtl/rv32_pipe_pkg.sv
// Shared RV32IM pipeline definitions.
// Holds the branch-redirect FSM state type and the pipeline constants.
package rv32_pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } brc_state_e;

  // Flush counter width: $clog2(n+1), never below one bit.
  function automatic int brc_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/JALR redirect controller: target, fetch handshake, flushes.
// Optional target alignment check enabled by defining BRC_MISALIGN_CHK_EN.
module branch_redirect_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_branch_taken,
  input  logic                  ex_is_jalr,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ex_jalr_target,
  input  logic                  fetch_ready,
  output logic                  pc_redirect_valid,
  output logic [DATA_WIDTH-1:0] pc_redirect_target,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  busy,
  output logic                  misalign_trap,
  output logic [DATA_WIDTH-1:0] misalign_addr
);

  localparam int CW = brc_cnt_width(FLUSH_CYCLES);

  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);

  brc_state_e state;
  brc_state_e state_nx;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic [DATA_WIDTH-1:0] tgt_q;
  logic [DATA_WIDTH-1:0] tgt_nx;
  logic [DATA_WIDTH-1:0] calc_tgt;

  logic req;
  logic mis;
  logic trap_nx;

  logic valid_q;
  logic busy_q;

  assign req = ex_valid & (ex_branch_taken | ex_is_jalr);

  // JALR wins over a taken branch; JALR clears bit 0.
  always_comb begin
    calc_tgt = ex_pc + ex_imm;
    if (ex_is_jalr) begin
      calc_tgt = {ex_jalr_target[DATA_WIDTH-1:1], 1'b0};
    end
  end

`ifdef BRC_MISALIGN_CHK_EN
  assign mis = calc_tgt[1];
`else
  assign mis = 1'b0;
`endif

  // Next-state logic; requests outside IDLE are wrong-path and dropped.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tgt_nx   = tgt_q;
    trap_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (mis) begin
            trap_nx = 1'b1;
          end else begin
            state_nx = REDIRECT;
            tgt_nx   = calc_tgt;
          end
        end
      end
      REDIRECT: begin
        if (fetch_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = FLUSH;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      FLUSH: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter, target and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tgt_q   <= tgt_nx;
      valid_q <= (state_nx == REDIRECT);
      busy_q  <= (state_nx != IDLE);
    end
  end

  assign pc_redirect_valid  = valid_q;
  assign pc_redirect_target = tgt_q;
  assign flush_if_id        = busy_q;
  assign flush_id_ex        = busy_q;
  assign busy               = busy_q;

`ifdef BRC_MISALIGN_CHK_EN
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] addr_q;

  // One-cycle trap pulse carrying the offending target.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
      addr_q <= '0;
    end else begin
      trap_q <= trap_nx;
      addr_q <= trap_nx ? calc_tgt : '0;
    end
  end

  assign misalign_trap = trap_q;
  assign misalign_addr = addr_q;
`else
  logic unused_trap;
  assign unused_trap   = trap_nx;
  assign misalign_trap = 1'b0;
  assign misalign_addr = '0;
`endif

  // Fetch must see a held, stable target until it accepts.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (pc_redirect_valid && !fetch_ready) |=>
      (pc_redirect_valid && $stable(pc_redirect_target)));

  // Flush and busy always track each other.
  a_flush: assert property (@(posedge clk)
    (flush_if_id == busy) && (flush_id_ex == busy));

endmodule
